// File: rtl/rc5_pkg.sv
// rc5_pkg: shared widths, mode encodings and sequencer state type for the
// rc5 host-side sequencer slice.
package rc5_pkg;

    localparam int unsigned RC5_KEY_W = 128;
    localparam int unsigned RC5_BLK_W = 64;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        KEY_REQ,
        KEY_WAIT,
        READY,
        SEND,
        WAIT_RES
    } state_e;

    // States in which the host may (re)load a key.
    function automatic logic host_can_load(input state_e s);
        return (s == IDLE) || (s == READY);
    endfunction

endpackage

// File: rtl/rc5_res_fifo.sv
// rc5_res_fifo: synchronous result FIFO, DEPTH x WIDTH.
// Ports:
//   clk, rst      clock, synchronous active-high reset (flushes FIFO)
//   push, din     write request and data; ignored when full
//   pop           read request; ignored when empty
//   dout          head entry, driven 0 when empty
//   full, empty   occupancy flags
//   count         number of stored entries
module rc5_res_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [WIDTH-1:0] mem_d [0:DEPTH-1];
    logic             do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem_q[rd_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/rc5_host_seq.sv
// rc5_host_seq: initiator-side sequencer for the rc5_core key/data interface.
// Takes key loads and 64-bit blocks from the host, pulses the core's key_en /
// din_en, waits for key_ok / dout_en under a watchdog, and returns results
// through a small result FIFO. One block in flight at a time.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   h_key, h_key_ld              host key and 1-cycle load request
//   h_mode, h_blk, h_blk_vld/rdy host block input (mode latched per block)
//   h_res, h_res_vld/rdy         host result output (FIFO head)
//   h_err                        sticky watchdog timeout flag
//   busy                         sequencer is not in IDLE/READY
//   c_flag, c_key, c_key_en      core key path and mode flag
//   c_key_ok                     core key ready (level)
//   c_din, c_din_en              core data input and strobe
//   c_dout, c_dout_en            core result and strobe
module rc5_host_seq
    import rc5_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 8,
    parameter int unsigned RES_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [RC5_KEY_W-1:0] h_key,
    input  logic                 h_key_ld,
    input  logic                 h_mode,
    input  logic [RC5_BLK_W-1:0] h_blk,
    input  logic                 h_blk_vld,
    output logic                 h_blk_rdy,
    output logic [RC5_BLK_W-1:0] h_res,
    output logic                 h_res_vld,
    input  logic                 h_res_rdy,
    output logic                 h_err,
    output logic                 busy,
    output logic                 c_flag,
    output logic [RC5_KEY_W-1:0] c_key,
    output logic                 c_key_en,
    input  logic                 c_key_ok,
    output logic [RC5_BLK_W-1:0] c_din,
    output logic                 c_din_en,
    input  logic [RC5_BLK_W-1:0] c_dout,
    input  logic                 c_dout_en
);

    localparam int unsigned CNT_W = $clog2(RES_DEPTH) + 1;

    state_e               state_q, state_d;
    logic [RC5_KEY_W-1:0] key_q, key_d;
    logic [RC5_BLK_W-1:0] din_q, din_d;
    logic                 flag_q, flag_d;
    logic                 err_q, err_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;

    logic                 can_load;
    logic                 wd_expired;
    logic                 fifo_push;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;

    assign can_load   = host_can_load(state_q);
    assign wd_expired = &wd_q;

    // A key load in READY pre-empts a block offered in the same cycle.
    assign h_blk_rdy  = (state_q == READY) && !h_key_ld && !fifo_full;

    // A response arriving on the watchdog's last cycle is dropped with the timeout.
    assign fifo_push  = (state_q == WAIT_RES) && c_dout_en && !wd_expired;

    assign h_res_vld  = !fifo_empty;
    assign h_err      = err_q;
    assign busy       = !can_load;
    assign c_flag     = flag_q;
    assign c_key      = key_q;
    assign c_key_en   = (state_q == KEY_REQ);
    assign c_din      = din_q;
    assign c_din_en   = (state_q == SEND);

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        din_d   = din_q;
        flag_d  = flag_q;
        err_d   = err_q;
        wd_d    = wd_q;

        if (can_load && h_key_ld) begin
            key_d   = h_key;
            err_d   = 1'b0;
            state_d = KEY_REQ;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                KEY_REQ: begin
                    // key_ok is not looked at here, so a stale level is ignored.
                    wd_d    = '0;
                    state_d = KEY_WAIT;
                end
                KEY_WAIT: begin
                    if (wd_expired) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (c_key_ok) begin
                        state_d = READY;
                    end else begin
                        wd_d = wd_q + TIMEOUT_W'(1);
                    end
                end
                READY: begin
                    if (h_blk_vld && !fifo_full) begin
                        din_d   = h_blk;
                        flag_d  = h_mode;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    wd_d    = '0;
                    state_d = WAIT_RES;
                end
                WAIT_RES: begin
                    if (wd_expired) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (c_dout_en) begin
                        state_d = READY;
                    end else begin
                        wd_d = wd_q + TIMEOUT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            din_q   <= '0;
            flag_q  <= 1'b0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            din_q   <= din_d;
            flag_q  <= flag_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    rc5_res_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH (RC5_BLK_W)
    ) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (c_dout),
        .pop   (h_res_rdy),
        .dout  (h_res),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // READY gating guarantees a free slot for the single in-flight block.
    a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && fifo_full));
    a_count_in_range : assert property (@(posedge clk) disable iff (rst)
        fifo_count <= CNT_W'(RES_DEPTH));

endmodule

// File: tb/tb_rc5_host_seq.sv
module tb_rc5_host_seq;
    import rc5_pkg::*;

    logic          clk;
    logic          rst;
    logic [127:0]  h_key;
    logic          h_key_ld;
    logic          h_mode;
    logic [63:0]   h_blk;
    logic          h_blk_vld;
    logic          h_blk_rdy;
    logic [63:0]   h_res;
    logic          h_res_vld;
    logic          h_res_rdy;
    logic          h_err;
    logic          busy;
    logic          c_flag;
    logic [127:0]  c_key;
    logic          c_key_en;
    logic          c_key_ok;
    logic [63:0]   c_din;
    logic          c_din_en;
    logic [63:0]   c_dout;
    logic          c_dout_en;

    int n_cmp = 0;
    int n_bad = 0;

    rc5_host_seq #(
        .TIMEOUT_W (8),
        .RES_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .h_key     (h_key),
        .h_key_ld  (h_key_ld),
        .h_mode    (h_mode),
        .h_blk     (h_blk),
        .h_blk_vld (h_blk_vld),
        .h_blk_rdy (h_blk_rdy),
        .h_res     (h_res),
        .h_res_vld (h_res_vld),
        .h_res_rdy (h_res_rdy),
        .h_err     (h_err),
        .busy      (busy),
        .c_flag    (c_flag),
        .c_key     (c_key),
        .c_key_en  (c_key_en),
        .c_key_ok  (c_key_ok),
        .c_din     (c_din),
        .c_din_en  (c_din_en),
        .c_dout    (c_dout),
        .c_dout_en (c_dout_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for rc5_core: the known all-zero encrypt vector,
    // otherwise an arbitrary but deterministic mix of data, key and mode.
    function automatic logic [63:0] core_fn(input logic [63:0] d, input logic m,
                                            input logic [127:0] k);
        if (k == '0 && d == '0 && m == MODE_ENC) return 64'h21A5DBEE154B8F6D;
        return {d[31:0], d[63:32]} ^ k[63:0] ^ {k[95:64], k[127:96]} ^ {64{m}};
    endfunction

    // ---------------- core model ----------------
    int          key_lat   = 5;
    int          core_lat  = 2;
    bit          core_mute = 0;
    bit          late_kick = 0;
    int          key_cnt   = 0;
    int          pend_cnt  = 0;
    bit          pend      = 0;
    logic [63:0] pend_val;

    initial begin
        c_key_ok  = 1'b0;
        c_dout_en = 1'b0;
        c_dout    = '0;
        forever begin
            @(posedge clk);
            #1;
            c_dout_en = 1'b0;
            c_dout    = '0;
            if (c_key_en) begin
                c_key_ok = 1'b0;
                key_cnt  = key_lat;
            end else if (key_cnt > 0) begin
                key_cnt--;
                if (key_cnt == 0) c_key_ok = 1'b1;
            end
            if (late_kick) begin
                c_dout_en = 1'b1;
                c_dout    = {32'hDEAD0000, $urandom};
                late_kick = 0;
            end else if (c_din_en) begin
                pend     = 1;
                pend_cnt = core_lat;
                pend_val = core_fn(c_din, c_flag, c_key);
            end else if (pend) begin
                pend_cnt--;
                if (pend_cnt <= 0) begin
                    pend = 0;
                    if (!core_mute) begin
                        c_dout_en = 1'b1;
                        c_dout    = pend_val;
                    end
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [127:0] cur_key;
    logic [63:0]  exp_q[$];
    bit           acc_prev = 0;
    logic [63:0]  prev_blk;
    logic         prev_mode;
    int           n_pop = 0;
    bit           rand_rdy = 0;

    always @(negedge clk) begin
        if (rst) begin
            acc_prev = 0;
        end else begin
            if (acc_prev) begin
                n_cmp++;
                if (c_din_en !== 1'b1 || c_din !== prev_blk || c_flag !== prev_mode) begin
                    n_bad++;
                    $display("FAIL din_issue: en=%b din=%h flag=%b expected en=1 din=%h flag=%b",
                             c_din_en, c_din, c_flag, prev_blk, prev_mode);
                end
            end else if (c_din_en !== 1'b0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_din_en: got %b expected 0", c_din_en);
            end
            acc_prev = h_blk_vld && h_blk_rdy;
            if (acc_prev) begin
                prev_blk  = h_blk;
                prev_mode = h_mode;
                exp_q.push_back(core_fn(h_blk, h_mode, cur_key));
            end
            if (h_res_vld && h_res_rdy) begin
                n_cmp++;
                n_pop++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_result: got %h expected none", h_res);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    if (h_res !== e) begin
                        n_bad++;
                        $display("FAIL result_data: got %h expected %h", h_res, e);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic offer(input logic [63:0] blk, input logic mode, input int budget,
                         output bit ok);
        h_blk     = blk;
        h_mode    = mode;
        h_blk_vld = 1'b1;
        ok        = 0;
        for (int i = 0; i < budget; i++) begin
            if (rand_rdy) h_res_rdy = 1'($urandom_range(0, 1));
            #1;
            if (h_blk_rdy) begin
                ok = 1;
                break;
            end
            step();
        end
        if (ok) step();
        h_blk_vld = 1'b0;
    endtask

    task automatic load_key(input logic [127:0] key, output int pulses, output int cyc,
                            output logic err_at_req, output logic [127:0] key_at_req);
        h_key    = key;
        h_key_ld = 1'b1;
        step();
        h_key_ld   = 1'b0;
        cur_key    = key;
        err_at_req = h_err;
        key_at_req = c_key;
        pulses     = 0;
        cyc        = 0;
        for (int i = 0; i < 50; i++) begin
            if (c_key_en) pulses++;
            if (!busy) break;
            step();
            cyc++;
        end
    endtask

    task automatic drain(input int n);
        h_res_rdy = 1'b1;
        for (int i = 0; i < n; i++) step();
        h_res_rdy = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1;
                break;
            end
            step();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        h_key = '0; h_key_ld = 0; h_mode = 0; h_blk = '0; h_blk_vld = 0; h_res_rdy = 0;
        cur_key = '0;
        repeat (3) step();
        n_cmp++;
        if ({h_blk_rdy, h_res_vld, h_err, busy} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got rdy/vld/err/busy=%b expected 0000",
                     {h_blk_rdy, h_res_vld, h_err, busy});
        end
        n_cmp++;
        if ({c_flag, c_key_en, c_din_en} !== 3'b0 || c_key !== '0 || c_din !== '0 || h_res !== '0) begin
            n_bad++;
            $display("FAIL reset_core_out: got key=%h din=%h res=%h expected all 0",
                     c_key, c_din, h_res);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_key_load();
        int pulses, cyc;
        logic e;
        logic [127:0] k;
        key_lat = 5;
        load_key(128'h0, pulses, cyc, e, k);
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL key_en_pulses: got %0d expected 1", pulses);
        end
        n_cmp++;
        if (cyc !== key_lat + 1) begin
            n_bad++;
            $display("FAIL key_ready_latency: got %0d expected %0d", cyc, key_lat + 1);
        end
        n_cmp++;
        if (busy !== 1'b0 || h_blk_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL key_ready_state: got busy=%b rdy=%b expected busy=0 rdy=1", busy, h_blk_rdy);
        end
    endtask

    task automatic test_encrypt();
        bit ok;
        int seen;
        core_lat  = 3;
        h_res_rdy = 1'b0;
        offer(64'h0, MODE_ENC, 5, ok);
        n_cmp++;
        if (!ok || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL enc_accept: got ok=%0d busy=%b expected 1 1", ok, busy);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (c_dout_en) begin
                seen = 1;
                break;
            end
        end
        n_cmp++;
        if (seen != 1 || h_res_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL enc_dout_cycle: got seen=%0d vld=%b expected 1 0", seen, h_res_vld);
        end
        step();
        n_cmp++;
        if (h_res_vld !== 1'b1 || h_res !== 64'h21A5DBEE154B8F6D) begin
            n_bad++;
            $display("FAIL enc_result: got vld=%b res=%h expected 1 21a5dbee154b8f6d", h_res_vld, h_res);
        end
        drain(1);
        n_cmp++;
        if (h_res_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL enc_pop: got vld=%b expected 0", h_res_vld);
        end
    endtask

    task automatic test_backpressure();
        bit ok[3];
        logic [63:0] b[3];
        logic m[3];
        int pops0;
        h_res_rdy = 1'b0;
        core_lat  = $urandom_range(1, 4);
        for (int i = 0; i < 3; i++) begin
            b[i] = {$urandom, $urandom};
            m[i] = 1'($urandom_range(0, 1));
            offer(b[i], m[i], 30, ok[i]);
        end
        n_cmp++;
        if (ok[0] != 1 || ok[1] != 1 || ok[2] != 0) begin
            n_bad++;
            $display("FAIL bp_accepts: got %0d%0d%0d expected 110", ok[0], ok[1], ok[2]);
        end
        n_cmp++;
        if (h_res_vld !== 1'b1 || exp_q.size() != 2 || h_res !== exp_q[0]) begin
            n_bad++;
            $display("FAIL bp_head: got vld=%b res=%h queued=%0d expected head of 2", h_res_vld, h_res, exp_q.size());
        end
        pops0 = n_pop;
        h_res_rdy = 1'b1;
        offer(b[2], m[2], 10, ok[2]);
        drain(20);
        n_cmp++;
        if (ok[2] != 1 || n_pop - pops0 != 3 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL bp_release: got ok=%0d pops=%0d left=%0d expected 1 3 0", ok[2], n_pop - pops0, exp_q.size());
        end
    endtask

    task automatic test_random();
        bit ok;
        int n_ok = 0;
        rand_rdy = 1;
        for (int i = 0; i < 24; i++) begin
            core_lat = $urandom_range(1, 6);
            offer({$urandom, $urandom}, 1'($urandom_range(0, 1)), 80, ok);
            if (ok) n_ok++;
        end
        rand_rdy = 0;
        drain(20);
        n_cmp++;
        if (n_ok != 24 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL random_stream: got accepted=%0d left=%0d expected 24 0", n_ok, exp_q.size());
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int cnt, pulses, cyc, pops0;
        logic e;
        logic [127:0] k;
        h_res_rdy = 1'b0;
        core_lat  = 2;
        offer({$urandom, $urandom}, MODE_DEC, 10, ok);
        wait_ready(20, ok);
        core_mute = 1;
        offer({$urandom, $urandom}, MODE_ENC, 10, ok);
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            cnt++;
            if (h_err) break;
        end
        n_cmp++;
        if (h_err !== 1'b1 || cnt < 255 || cnt > 258) begin
            n_bad++;
            $display("FAIL wd_timeout: got err=%b after %0d cycles expected 1 after 255..258", h_err, cnt);
        end
        void'(exp_q.pop_back());
        n_cmp++;
        if (busy !== 1'b0 || h_blk_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL wd_idle: got busy=%b rdy=%b expected 0 0", busy, h_blk_rdy);
        end
        n_cmp++;
        if (h_res_vld !== 1'b1 || h_res !== exp_q[0]) begin
            n_bad++;
            $display("FAIL wd_fifo_kept: got vld=%b res=%h expected 1 %h", h_res_vld, h_res, exp_q[0]);
        end
        core_mute = 0;
        late_kick = 1;
        step();
        step();
        load_key({$urandom, $urandom, $urandom, $urandom}, pulses, cyc, e, k);
        n_cmp++;
        if (e !== 1'b0 || h_err !== 1'b0 || k !== cur_key) begin
            n_bad++;
            $display("FAIL wd_err_clear: got err=%b key=%h expected 0 %h", e, k, cur_key);
        end
        pops0 = n_pop;
        drain(4);
        n_cmp++;
        if (n_pop - pops0 != 1 || h_res_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL late_dout_ignored: got pops=%0d vld=%b expected 1 0", n_pop - pops0, h_res_vld);
        end
    endtask

    task automatic test_collision();
        bit ok;
        int pulses;
        logic [127:0] nk, old;
        nk = {$urandom, $urandom, $urandom, $urandom};
        h_key     = nk;
        h_key_ld  = 1'b1;
        h_blk     = {$urandom, $urandom};
        h_blk_vld = 1'b1;
        #1;
        n_cmp++;
        if (h_blk_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL coll_rdy: got %b expected 0", h_blk_rdy);
        end
        step();
        h_key_ld  = 1'b0;
        h_blk_vld = 1'b0;
        cur_key   = nk;
        n_cmp++;
        if (c_key_en !== 1'b1 || c_key !== nk) begin
            n_bad++;
            $display("FAIL coll_key_path: got en=%b key=%h expected 1 %h", c_key_en, c_key, nk);
        end
        wait_ready(30, ok);
        old = c_key;
        core_lat = 10;
        offer({$urandom, $urandom}, 1'($urandom_range(0, 1)), 5, ok);
        step();
        h_key    = ~nk;
        h_key_ld = 1'b1;
        step();
        h_key_ld = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            if (c_key_en) pulses++;
            step();
        end
        n_cmp++;
        if (pulses != 0 || c_key !== old || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL ld_in_wait_ignored: got pulses=%0d key=%h busy=%b expected 0 %h 1", pulses, c_key, busy, old);
        end
        drain(15);
        n_cmp++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL coll_result: got left=%0d busy=%b expected 0 0", exp_q.size(), busy);
        end
    endtask

    task automatic test_reset_midflight();
        bit ok;
        bit saw_vld = 0;
        core_lat  = 6;
        h_res_rdy = 1'b1;
        offer({$urandom, $urandom}, MODE_DEC, 5, ok);
        step();
        step();
        rst = 1'b1;
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (h_res_vld) saw_vld = 1;
            step();
        end
        h_res_rdy = 1'b0;
        n_cmp++;
        if (saw_vld || h_res_vld !== 1'b0 || h_res !== '0) begin
            n_bad++;
            $display("FAIL rst_result_dropped: got vld=%b res=%h expected 0 0", saw_vld, h_res);
        end
        n_cmp++;
        if ({h_blk_rdy, h_err, busy, c_flag, c_key_en, c_din_en} !== 6'b0 || c_key !== '0 || c_din !== '0) begin
            n_bad++;
            $display("FAIL rst_outputs: got flags=%b key=%h din=%h expected 0",
                     {h_blk_rdy, h_err, busy, c_flag, c_key_en, c_din_en}, c_key, c_din);
        end
    endtask

    initial begin
        test_reset();
        test_key_load();
        test_encrypt();
        test_backpressure();
        test_random();
        test_timeout();
        test_collision();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
